// File: rtl/file_register_access_unit.sv
// PIC16F data-memory initiator: forms banked/indirect addresses and runs read, write and
// read-modify-write transactions against the file register RAM or the SFR bus.
module file_register_access_unit #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int SFR_TOP    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [6:0]            req_f,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            rp,
  input  logic                  irp,
  input  logic [7:0]            fsr,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  wb_valid,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] sfr_addr,
  output logic                  sfr_rd_en,
  output logic                  sfr_wr_en,
  output logic [DATA_WIDTH-1:0] sfr_wdata,
  input  logic [DATA_WIDTH-1:0] sfr_rdata
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] RSP  = 3'd2;
  localparam logic [2:0] WBW  = 3'd3;
  localparam logic [2:0] WR   = 3'd4;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;
  localparam logic [6:0] SFR_TOP_L = 7'(SFR_TOP);
  localparam logic [6:0] COMMON_LO = 7'h70;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  sfr_q;
  logic                  null_q;
  logic                  rmw_q;

  logic                  indirect;
  logic [6:0]            low7;
  logic [1:0]            bank;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  sfr_d;
  logic                  null_d;

  always_comb begin
    indirect = (req_f == 7'd0);
    low7     = indirect ? fsr[6:0] : req_f;
    bank     = indirect ? {irp, fsr[7]} : rp;
    // 0x70..0x7F is the common RAM block mirrored in every bank
    if (low7 >= COMMON_LO) bank = 2'b00;
    addr_d   = ADDR_WIDTH'({bank, low7});
    sfr_d    = (low7 < SFR_TOP_L);
    null_d   = indirect && (fsr == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      sfr_q       <= 1'b0;
      null_q      <= 1'b0;
      rmw_q       <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= addr_d;
            sfr_q  <= sfr_d;
            null_q <= null_d;
            rmw_q  <= (req_op == OP_RMW);
            if (req_op == OP_WRITE) begin
              wdata_q <= req_wdata;
              state   <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: state <= RSP;
        RSP: begin
          rdata       <= null_q ? '0 : (sfr_q ? sfr_rdata : ram_rdata);
          rdata_valid <= 1'b1;
          if (rmw_q) begin
            state <= WBW;
          end else begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        WBW: begin
          if (wb_valid) begin
            wdata_q <= wb_data;
            state   <= WR;
          end
        end
        WR: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from registered state only, so IDLE/RSP/WBW can never strobe
  assign req_ready = (state == IDLE);
  assign ram_addr  = addr_q;
  assign sfr_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign sfr_wdata = wdata_q;
  assign ram_wr_en = (state == WR) && !sfr_q && !null_q;
  assign sfr_wr_en = (state == WR) &&  sfr_q && !null_q;
  assign sfr_rd_en = (state == RD) &&  sfr_q && !null_q;

endmodule
